// File: rtl/data_transposer.sv
// Packs XLEN-bit input words of P-bit elements into a NUM_WORDS-element block,
// then streams the block out as P bit-plane words, MSB plane first.
module data_transposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic [XLEN-1:0]         iword,
  input  logic                    start,
  output logic                    busy,
  output logic                    mvu_wr_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
  output logic [MVU_DATA_LEN-1:0] mvu_wr_word,
  output logic [31:0]             qaddr
);

  localparam int PW = $clog2(MAX_DATA_PREC + 1);
  localparam int CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t                                      state;
  logic [PW-1:0]                               p_r, p_in, plane;
  logic [CW-1:0]                               ecnt;
  logic [MVU_ADDR_LEN-1:0]                     base, wcnt;
  logic [NUM_WORDS-1:0][MAX_DATA_PREC-1:0]     elem, elem_nxt;
  logic [31:0]                                 epw, fill;
  logic [MAX_DATA_PREC-1:0]                    pmask;

  function automatic logic [MVU_DATA_LEN-1:0] bitplane(
    input logic [NUM_WORDS-1:0][MAX_DATA_PREC-1:0] a,
    input logic [PW-1:0]                           p
  );
    logic [MAX_DATA_PREC-1:0] t;
    bitplane = '0;
    for (int e = 0; e < NUM_WORDS; e++) begin
      t           = a[e] >> p;
      bitplane[e] = t[0];
    end
  endfunction

  // Out-of-range precision falls back to the widest supported element.
  always_comb begin
    p_in = PW'(MAX_DATA_PREC);
    if (prec != 32'd0 && prec <= 32'(MAX_DATA_PREC)) p_in = PW'(prec);
  end

  assign epw   = (p_r == '0) ? 32'd0 : 32'(XLEN) / 32'(p_r);
  assign fill  = 32'(ecnt) + epw;
  assign pmask = MAX_DATA_PREC'((32'd1 << p_r) - 32'd1);

  // Each slot picks its element from the incoming word by offset from ecnt;
  // elements landing past the last slot simply have no slot to go to.
  always_comb begin
    elem_nxt = elem;
    for (int j = 0; j < NUM_WORDS; j++) begin
      if (j >= int'(ecnt) && (j - int'(ecnt)) < int'(epw))
        elem_nxt[j] = MAX_DATA_PREC'(iword >> ((j - int'(ecnt)) * int'(p_r))) & pmask;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      p_r         <= '0;
      base        <= '0;
      wcnt        <= '0;
      ecnt        <= '0;
      plane       <= '0;
      qaddr       <= '0;
      elem        <= '0;
      busy        <= 1'b0;
      mvu_wr_en   <= 1'b0;
      mvu_wr_addr <= '0;
      mvu_wr_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_r   <= p_in;
            base  <= baddr[MVU_ADDR_LEN-1:0];
            ecnt  <= '0;
            qaddr <= '0;
            plane <= '0;
            wcnt  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!start) begin
            state <= IDLE;
          end else begin
            elem  <= elem_nxt;
            qaddr <= qaddr + 32'd1;
            if (fill >= 32'(NUM_WORDS)) begin
              // First plane is built from the block as it stands after this word.
              ecnt        <= CW'(NUM_WORDS);
              plane       <= p_r - PW'(1);
              busy        <= 1'b1;
              mvu_wr_en   <= 1'b1;
              mvu_wr_addr <= base + wcnt;
              mvu_wr_word <= bitplane(elem_nxt, p_r - PW'(1));
              state       <= WRITE;
            end else begin
              ecnt <= CW'(fill);
            end
          end
        end
        WRITE: begin
          wcnt <= wcnt + MVU_ADDR_LEN'(1);
          if (plane != '0) begin
            plane       <= plane - PW'(1);
            mvu_wr_addr <= base + wcnt + MVU_ADDR_LEN'(1);
            mvu_wr_word <= bitplane(elem, plane - PW'(1));
          end else begin
            busy        <= 1'b0;
            mvu_wr_en   <= 1'b0;
            mvu_wr_addr <= '0;
            mvu_wr_word <= '0;
            ecnt        <= '0;
            state       <= start ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_transposer.sv
// Directed bench for data_transposer: fills blocks at several precisions and
// checks the bit-plane writes, addresses, qaddr and abort behaviour.
module tb_data_transposer;
  localparam int NW = 64, XL = 32, AL = 15, DL = 64, MP = 16;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0]   prec = '0, baddr = '0;
  logic [XL-1:0] iword = '0;
  logic          busy, mvu_wr_en;
  logic [AL-1:0] mvu_wr_addr;
  logic [DL-1:0] mvu_wr_word;
  logic [31:0]   qaddr;

  data_transposer #(.NUM_WORDS(NW), .XLEN(XL), .MVU_ADDR_LEN(AL),
                    .MVU_DATA_LEN(DL), .MAX_DATA_PREC(MP)) dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .iword(iword),
    .start(start), .busy(busy), .mvu_wr_en(mvu_wr_en),
    .mvu_wr_addr(mvu_wr_addr), .mvu_wr_word(mvu_wr_word), .qaddr(qaddr));

  always #5 clk = ~clk;

  int total = 0, passed = 0, idle_bad = 0;
  logic [AL-1:0] log_a[$];
  logic [DL-1:0] log_w[$];

  always @(negedge clk) begin
    if (mvu_wr_en) begin
      log_a.push_back(mvu_wr_addr);
      log_w.push_back(mvu_wr_word);
    end else if (mvu_wr_addr != '0 || mvu_wr_word != '0) begin
      idle_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_log(input string tag, input int idx, input int expa, input logic [63:0] expw);
    logic [63:0] a, w;
    a = 'x;
    w = 'x;
    if (idx < log_a.size()) begin
      a = 64'(log_a[idx]);
      w = 64'(log_w[idx]);
    end
    check({tag, "_addr"}, a, 64'(expa));
    check({tag, "_word"}, w, expw);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick;
      n++;
    end
    check("wait_idle", 64'(busy), 64'd0);
  endtask

  task automatic clear_log;
    log_a.delete();
    log_w.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b1;
    repeat (3) tick;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_wr_en", 64'(mvu_wr_en), 64'd0);
    check("rst_addr",  64'(mvu_wr_addr), 64'd0);
    check("rst_word",  64'(mvu_wr_word), 64'd0);
    check("rst_qaddr", 64'(qaddr), 64'd0);
    rst_n = 1'b0;
    tick;

    // prec 8, every element = 1 -> only plane 0 is set
    clear_log();
    prec = 8; baddr = 0; iword = 32'h0101_0101; start = 1'b1;
    tick;
    repeat (15) tick;
    check("t1_busy_early", 64'(busy), 64'd0);
    tick;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_qaddr", 64'(qaddr), 64'd16);
    start = 1'b0;
    wait_idle(20);
    check("t1_nwr", 64'(log_a.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_log("t1", i, i, (i == 7) ? ONES : 64'd0);

    // prec 8, element e = e
    clear_log();
    prec = 8; baddr = 0; start = 1'b1;
    tick;
    for (int w = 0; w < 16; w++) begin
      iword = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      tick;
    end
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_qaddr", 64'(qaddr), 64'd16);
    start = 1'b0;
    wait_idle(20);
    check("t2_nwr", 64'(log_a.size()), 64'd8);
    check_log("t2_p7", 0, 0, 64'd0);
    check_log("t2_p5", 2, 2, 64'hFFFF_FFFF_0000_0000);
    check_log("t2_p4", 3, 3, 64'hFFFF_0000_FFFF_0000);
    check_log("t2_p0", 7, 7, 64'hAAAA_AAAA_AAAA_AAAA);

    // prec 16 at base 0x100; prec/baddr changes mid-LOAD must be ignored
    clear_log();
    prec = 16; baddr = 32'h100; iword = 32'h8000_8000; start = 1'b1;
    tick;
    prec = 4; baddr = 0;
    repeat (31) tick;
    check("t3_busy_early", 64'(busy), 64'd0);
    tick;
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_qaddr", 64'(qaddr), 64'd32);
    start = 1'b0;
    wait_idle(40);
    check("t3_nwr", 64'(log_a.size()), 64'd16);
    for (int i = 0; i < 16; i++) check_log("t3", i, 32'h100 + i, (i == 0) ? ONES : 64'd0);

    // prec 4, two back-to-back blocks with start held
    clear_log();
    prec = 4; baddr = 0; iword = 32'h7654_3210; start = 1'b1;
    tick;
    repeat (8) tick;
    check("t4_busy_b1", 64'(busy), 64'd1);
    iword = 32'hFFFF_FFFF;
    repeat (4) tick;
    check("t4_reload", 64'(busy), 64'd0);
    repeat (8) tick;
    check("t4_busy_b2", 64'(busy), 64'd1);
    check("t4_qaddr", 64'(qaddr), 64'd16);
    start = 1'b0;
    wait_idle(20);
    check("t4_nwr", 64'(log_a.size()), 64'd8);
    check_log("t4_p3", 0, 0, 64'd0);
    check_log("t4_p2", 1, 1, 64'hF0F0_F0F0_F0F0_F0F0);
    check_log("t4_p1", 2, 2, 64'hCCCC_CCCC_CCCC_CCCC);
    check_log("t4_p0", 3, 3, 64'hAAAA_AAAA_AAAA_AAAA);
    for (int i = 4; i < 8; i++) check_log("t4_b2", i, i, ONES);

    // reset during WRITE after three planes
    clear_log();
    prec = 8; baddr = 0; iword = 32'h0101_0101; start = 1'b1;
    tick;
    repeat (16) tick;
    check("t5_busy", 64'(busy), 64'd1);
    repeat (3) tick;
    rst_n = 1'b1;
    #1;
    check("t5_wr_en", 64'(mvu_wr_en), 64'd0);
    check("t5_busy0", 64'(busy), 64'd0);
    check("t5_qaddr", 64'(qaddr), 64'd0);
    check("t5_addr",  64'(mvu_wr_addr), 64'd0);
    check("t5_word",  64'(mvu_wr_word), 64'd0);
    start = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    repeat (30) tick;
    check("t5_nwr", 64'(log_a.size()), 64'd3);
    check_log("t5_p5", 2, 2, 64'd0);

    // start dropped mid-LOAD discards the partial block
    clear_log();
    prec = 8; baddr = 0; iword = 32'h0101_0101; start = 1'b1;
    tick;
    repeat (5) tick;
    start = 1'b0;
    tick;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_qaddr", 64'(qaddr), 64'd5);
    repeat (20) tick;
    check("t6_qaddr_hold", 64'(qaddr), 64'd5);
    check("t6_nwr", 64'(log_a.size()), 64'd0);

    check("idle_outputs_zero", 64'(idle_bad), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
